// File: rtl/md_unit_if.sv
// E-stage bundle between the pipeline and the multiply/divide unit.
// Includes the HI/LO trace outputs and the unit's state for debug.
interface md_unit_if;
  logic [3:0]  E_mdop;
  logic [31:0] E_rs_m;
  logic [31:0] E_rt_m;
  logic        D_is_md;
  logic [31:0] md_rd;
  logic        busy;
  logic        start;
  logic        md_stall;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  // Handshake: the pipeline presents an op in E for one cycle. The unit
  // accepts ops 1..4 only while busy=0. md_stall holds D until busy falls,
  // so no second op or mthi/mtlo can arrive while an op is in flight.
  modport master (
    output E_mdop, E_rs_m, E_rt_m, D_is_md,
    input  md_rd, busy, start, md_stall, hi, lo, dbg_state
  );
  modport slave (
    input  E_mdop, E_rs_m, E_rt_m, D_is_md,
    output md_rd, busy, start, md_stall, hi, lo, dbg_state
  );
endinterface

// File: rtl/md_unit.sv
// Multi-cycle mult/multu/div/divu unit owning HI/LO; the result is computed at
// start, held in pending registers and committed after the busy countdown.
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic      clk,
  input  logic      reset_n,
  md_unit_if.slave  bus
);
  typedef enum logic {ST_IDLE = 1'b0, ST_RUN = 1'b1} state_t;

  localparam int MAX_N = (DIV_CYCLES > MULT_CYCLES) ? DIV_CYCLES : MULT_CYCLES;
  localparam int CW    = $clog2(MAX_N + 1);

  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_DIV   = 4'd3;
  localparam logic [3:0] OP_DIVU  = 4'd4;
  localparam logic [3:0] OP_MFHI  = 4'd5;
  localparam logic [3:0] OP_MFLO  = 4'd6;
  localparam logic [3:0] OP_MTHI  = 4'd7;
  localparam logic [3:0] OP_MTLO  = 4'd8;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0]   pend_q, pend_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;

  logic [31:0] rs, rt;
  logic        is_div, is_signed_div;
  logic [63:0] prod_s, prod_u, result;
  logic [31:0] dvd, dvs, q_mag, r_mag, quo, rem;

  assign rs = bus.E_rs_m;
  assign rt = bus.E_rt_m;

  assign bus.start     = (bus.E_mdop >= OP_MULT) && (bus.E_mdop <= OP_DIVU);
  assign bus.busy      = (state_q == ST_RUN);
  assign bus.md_stall  = bus.D_is_md & (bus.start | bus.busy);
  assign bus.hi        = hi_q;
  assign bus.lo        = lo_q;
  assign bus.dbg_state = state_q;
  assign bus.md_rd     = (bus.E_mdop == OP_MFHI) ? hi_q :
                         (bus.E_mdop == OP_MFLO) ? lo_q : 32'd0;

  // One unsigned divider serves both divides; signed div works on magnitudes,
  // which also makes 0x80000000 / -1 fall out as 0x80000000 rem 0.
  assign is_div        = (bus.E_mdop == OP_DIV) || (bus.E_mdop == OP_DIVU);
  assign is_signed_div = (bus.E_mdop == OP_DIV);
  assign dvd    = (is_signed_div && rs[31]) ? -rs : rs;
  assign dvs    = (is_signed_div && rt[31]) ? -rt : rt;
  assign q_mag  = (dvs == 32'd0) ? 32'd0 : dvd / dvs;
  assign r_mag  = (dvs == 32'd0) ? 32'd0 : dvd % dvs;
  assign quo    = (is_signed_div && (rs[31] ^ rt[31])) ? -q_mag : q_mag;
  assign rem    = (is_signed_div && rs[31]) ? -r_mag : r_mag;
  assign prod_s = {{32{rs[31]}}, rs} * {{32{rt[31]}}, rt};
  assign prod_u = {32'd0, rs} * {32'd0, rt};

  always_comb begin
    result = 64'd0;
    if (is_div) begin
      if (rt == 32'd0) result = {rs, 32'hFFFF_FFFF};
      else             result = {rem, quo};
    end else if (bus.E_mdop == OP_MULT) begin
      result = prod_s;
    end else if (bus.E_mdop == OP_MULTU) begin
      result = prod_u;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    pend_d  = pend_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          pend_d  = result;
          cnt_d   = is_div ? CW'(DIV_CYCLES) : CW'(MULT_CYCLES);
          state_d = ST_RUN;
        end else if (bus.E_mdop == OP_MTHI) begin
          hi_d = rs;
        end else if (bus.E_mdop == OP_MTLO) begin
          lo_d = rs;
        end
      end
      ST_RUN: begin
        if (cnt_q == CW'(1)) begin
          hi_d    = pend_q[63:32];
          lo_d    = pend_q[31:0];
          cnt_d   = '0;
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      pend_q  <= 64'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pend_q  <= pend_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
    end
  end

  // A new op while one is in flight is dropped; md_stall should prevent it.
  a_no_start_while_busy: assert property (
    @(posedge clk) disable iff (!reset_n) !(bus.busy && bus.start)
  );
endmodule

// File: tb/tb_md_unit.sv
// Bench for md_unit: scoreboard of expected {hi,lo} pushed at issue and
// popped when busy falls, plus directed checks of stall, mthi/mtlo and reset.
module tb_md_unit;
  logic clk;
  logic reset_n;
  int   total;
  int   bad;
  logic [63:0] exp_q[$];
  logic [31:0] model_hi, model_lo;

  md_unit_if bus ();

  md_unit #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic [3:0] op, input logic [31:0] rs,
                                        input logic [31:0] rt);
    int si, ti;
    longint a, b, q, r;
    logic [63:0] ua, ub, p;
    si = rs;
    ti = rt;
    a  = si;
    b  = ti;
    ua = {32'd0, rs};
    ub = {32'd0, rt};
    case (op)
      4'd1: begin q = a * b; return q; end
      4'd2: begin p = ua * ub; return p; end
      4'd3: begin
        if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
        q = a / b;
        r = a % b;
        return {r[31:0], q[31:0]};
      end
      4'd4: begin
        if (rt == 32'd0) return {rs, 32'hFFFF_FFFF};
        return {rs % rt, rs / rt};
      end
      default: return {model_hi, model_lo};
    endcase
  endfunction

  // Caller is mid-cycle (after a negedge) with busy=0; returns the same way.
  task automatic run_op(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                        input logic d_md, input int n_cyc);
    logic [63:0] exp, got;
    int bc, sc;
    exp_q.push_back(model(op, rs, rt));
    bus.E_mdop  = op;
    bus.E_rs_m  = rs;
    bus.E_rt_m  = rt;
    bus.D_is_md = d_md;
    #1;
    total++;
    if (bus.start !== 1'b1) begin
      bad++; $display("FAIL start op=%0d got=%b want=1", op, bus.start);
    end
    sc = bus.md_stall ? 1 : 0;
    @(negedge clk);
    bus.E_mdop = 4'd0;
    #1;
    bc = 0;
    while (bus.busy === 1'b1 && bc < 200) begin
      bc++;
      if (bus.md_stall) sc++;
      @(negedge clk);
      #1;
    end
    total++;
    if (bc !== n_cyc) begin
      bad++; $display("FAIL busy_cycles op=%0d got=%0d want=%0d", op, bc, n_cyc);
    end
    total++;
    if (sc !== (d_md ? n_cyc + 1 : 0)) begin
      bad++; $display("FAIL stall_cycles op=%0d got=%0d want=%0d", op, sc, d_md ? n_cyc + 1 : 0);
    end
    exp = exp_q.pop_front();
    got = {bus.hi, bus.lo};
    total++;
    if (got !== exp) begin
      bad++; $display("FAIL result op=%0d rs=%h rt=%h got=%h want=%h", op, rs, rt, got, exp);
    end
    model_hi = exp[63:32];
    model_lo = exp[31:0];
  endtask

  task automatic check_hilo(input string name, input logic [31:0] eh, input logic [31:0] el);
    total++;
    if (bus.hi !== eh || bus.lo !== el) begin
      bad++; $display("FAIL %s got hi=%h lo=%h want hi=%h lo=%h", name, bus.hi, bus.lo, eh, el);
    end
  endtask

  task automatic test_reset();
    bus.E_mdop = 4'd0; bus.E_rs_m = 32'd0; bus.E_rt_m = 32'd0; bus.D_is_md = 1'b0;
    reset_n = 1'b0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.hi !== 32'd0 || bus.lo !== 32'd0 || bus.md_stall !== 1'b0) begin
      bad++; $display("FAIL reset busy=%b hi=%h lo=%h stall=%b want 0", bus.busy, bus.hi, bus.lo, bus.md_stall);
    end
    reset_n = 1'b1;
    @(negedge clk);
    #1;
    model_hi = 32'd0;
    model_lo = 32'd0;
  endtask

  task automatic test_mult();
    run_op(4'd1, 32'hFFFF_FFFE, 32'd3, 1'b1, 5);
    check_hilo("mult_const", 32'hFFFF_FFFF, 32'hFFFF_FFFA);
    run_op(4'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b1, 5);
    check_hilo("multu_const", 32'hFFFF_FFFE, 32'h0000_0001);
  endtask

  task automatic test_non_md_no_stall();
    run_op(4'd1, 32'd7, 32'hFFFF_FFFD, 1'b0, 5);
    check_hilo("mult_neg", 32'hFFFF_FFFF, 32'hFFFF_FFEB);
  endtask

  task automatic test_div();
    run_op(4'd3, 32'hFFFF_FFF9, 32'd2, 1'b1, 10);
    check_hilo("div_const", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_op(4'd4, 32'd5, 32'd0, 1'b1, 10);
    check_hilo("divu_zero", 32'd5, 32'hFFFF_FFFF);
    run_op(4'd3, 32'h1234_5678, 32'd0, 1'b1, 10);
    check_hilo("div_zero", 32'h1234_5678, 32'hFFFF_FFFF);
    run_op(4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 10);
    check_hilo("div_ovf", 32'd0, 32'h8000_0000);
    run_op(4'd4, 32'hFFFF_FFF9, 32'd2, 1'b1, 10);
    check_hilo("divu_big", 32'd1, 32'h7FFF_FFFC);
  endtask

  task automatic test_mthi_mtlo();
    bus.E_mdop = 4'd7; bus.E_rs_m = 32'h0000_1234; bus.D_is_md = 1'b0;
    #1;
    check_hilo("mthi_before_edge", model_hi, model_lo);
    @(negedge clk);
    bus.E_mdop = 4'd5;
    #1;
    check_hilo("mthi_after_edge", 32'h0000_1234, model_lo);
    total++;
    if (bus.md_rd !== 32'h0000_1234) begin
      bad++; $display("FAIL mfhi got=%h want=%h", bus.md_rd, 32'h0000_1234);
    end
    bus.E_mdop = 4'd6;
    #1;
    total++;
    if (bus.md_rd !== model_lo) begin
      bad++; $display("FAIL mflo got=%h want=%h", bus.md_rd, model_lo);
    end
    bus.E_mdop = 4'd8; bus.E_rs_m = 32'h0000_0055;
    @(negedge clk);
    bus.E_mdop = 4'd9;
    #1;
    check_hilo("mtlo_keeps_hi", 32'h0000_1234, 32'h0000_0055);
    total++;
    if (bus.md_rd !== 32'd0 || bus.start !== 1'b0) begin
      bad++; $display("FAIL op9_idle md_rd=%h start=%b want 0", bus.md_rd, bus.start);
    end
    model_hi = 32'h0000_1234;
    model_lo = 32'h0000_0055;
    bus.E_mdop = 4'd0;
    #1;
  endtask

  task automatic test_back_to_back();
    logic [3:0] op;
    logic [31:0] rs, rt;
    for (int i = 0; i < 20; i++) begin
      op = 4'($urandom_range(1, 4));
      rs = $urandom;
      rt = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) rs = 32'h8000_0000;
      run_op(op, rs, rt, 1'($urandom_range(0, 1)), (op <= 4'd2) ? 5 : 10);
    end
    total++;
    if (exp_q.size() !== 0) begin
      bad++; $display("FAIL scoreboard_left got=%0d want=0", exp_q.size());
    end
  endtask

  task automatic test_reset_mid_div();
    bus.E_mdop = 4'd3; bus.E_rs_m = 32'd100; bus.E_rt_m = 32'd7; bus.D_is_md = 1'b1;
    @(negedge clk);
    bus.E_mdop = 4'd0;
    repeat (2) @(negedge clk);
    #1;
    total++;
    if (bus.busy !== 1'b1) begin
      bad++; $display("FAIL mid_div_busy got=%b want=1", bus.busy);
    end
    reset_n = 1'b0;
    #1;
    total++;
    if (bus.busy !== 1'b0 || bus.dbg_state !== 1'b0 || bus.md_stall !== 1'b0) begin
      bad++; $display("FAIL reset_abort busy=%b state=%b stall=%b want 0", bus.busy, bus.dbg_state, bus.md_stall);
    end
    check_hilo("reset_abort_hilo", 32'd0, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (15) @(negedge clk);
    #1;
    check_hilo("no_write_after_release", 32'd0, 32'd0);
    total++;
    if (bus.busy !== 1'b0) begin
      bad++; $display("FAIL busy_after_release got=%b want=0", bus.busy);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    model_hi = 32'd0;
    model_lo = 32'd0;
    test_reset();
    test_mult();
    test_non_md_no_stall();
    test_div();
    test_mthi_mtlo();
    test_back_to_back();
    test_reset_mid_div();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
